// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM-state and coherence-state types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [2:0] {IDLE, SNOOP, DATA, WB, INV, IFETCH} cc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or after ptr wins
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW:0] k;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            // one spare bit so ptr+i can wrap for any N, not only powers of two
            k = {1'b0, ptr} + (IW + 1)'(i);
            if (k >= (IW + 1)'(N)) begin
                k = k - (IW + 1)'(N);
            end
            if (!found && req[k[IW-1:0]]) begin
                found             = 1'b1;
                grant[k[IW-1:0]]  = 1'b1;
                idx               = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/coherence_arbiter_n.sv
// rtl/coherence_arbiter_n.sv - N-cache snooping coherence controller and single-port RAM arbiter
module coherence_arbiter_n
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter int WORDS = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0]       cctrans,
    input  logic [CPUS-1:0]       ccwrite,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    input  word_t                 ramload,
    input  ramstate_t             ramstate,
    output word_t                 ramaddr,
    output word_t                 ramstore,
    output logic                  ramREN,
    output logic                  ramWEN
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WW-1:0] LAST = WW'(WORDS - 1);

    cc_state_t     state;
    logic [IW-1:0] req, own, drr, irr;
    logic          hit;
    logic [WW-1:0] wcnt;

    logic [CPUS-1:0] dq, dgrant, igrant, others;
    logic [IW-1:0]   didx, iidx, snoop_own;
    logic            snoop_hit, access;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(CPUS - 1)) ? '0 : i + IW'(1);
    endfunction

    // a plain cctrans covers both the snooped miss and the shared-line write hit
    assign dq     = dWEN | cctrans;
    assign access = (ramstate == ACCESS);
    assign others = ~(CPUS'(1) << req);

    rr_arbiter #(.N(CPUS), .IW(IW)) u_darb (
        .req   (dq),
        .ptr   (drr),
        .grant (dgrant),
        .idx   (didx)
    );

    rr_arbiter #(.N(CPUS), .IW(IW)) u_iarb (
        .req   (iREN),
        .ptr   (irr),
        .grant (igrant),
        .idx   (iidx)
    );

    // lowest-numbered dirty holder other than the requester becomes the forwarder
    always_comb begin
        snoop_hit = 1'b0;
        snoop_own = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (IW'(j) != req && ccwrite[j]) begin
                snoop_hit = 1'b1;
                snoop_own = IW'(j);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            req   <= '0;
            own   <= '0;
            hit   <= 1'b0;
            wcnt  <= '0;
            drr   <= '0;
            irr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|dgrant) begin
                        req <= didx;
                        if (dWEN[didx])      state <= WB;
                        else if (dREN[didx]) state <= SNOOP;
                        else                 state <= INV;
                    end else if (|igrant) begin
                        req   <= iidx;
                        state <= IFETCH;
                    end
                end
                SNOOP: begin
                    hit   <= snoop_hit;
                    own   <= snoop_own;
                    state <= DATA;
                end
                DATA, WB: begin
                    if (access) begin
                        if (wcnt == LAST) begin
                            wcnt  <= '0;
                            drr   <= next_idx(req);
                            state <= IDLE;
                        end else begin
                            wcnt <= wcnt + WW'(1);
                        end
                    end
                end
                INV: begin
                    drr   <= next_idx(req);
                    state <= IDLE;
                end
                IFETCH: begin
                    if (access) begin
                        irr   <= next_idx(req);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dwait       = '1;
        iwait       = '1;
        dload       = '0;
        iload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            SNOOP: begin
                ccwait      = others;
                ccsnoopaddr = {CPUS{daddr[req]}};
            end
            DATA: begin
                ccwait  = others;
                ramaddr = daddr[req];
                if (hit) begin
                    // cache-to-cache forward doubles as the RAM write-through
                    ramWEN     = 1'b1;
                    ramstore   = dstore[own];
                    dload[req] = dstore[own];
                    dwait[req] = ~access;
                    dwait[own] = ~access;
                end else begin
                    ramREN     = 1'b1;
                    dload[req] = ramload;
                    dwait[req] = ~access;
                end
            end
            WB: begin
                ramWEN     = 1'b1;
                ramaddr    = daddr[req];
                ramstore   = dstore[req];
                dwait[req] = ~access;
            end
            INV: begin
                ccinv       = others;
                ccwait      = others;
                ccsnoopaddr = {CPUS{daddr[req]}};
                dwait[req]  = 1'b0;
            end
            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = iaddr[req];
                iload[req] = ramload;
                iwait[req] = ~access;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_arbiter_n.sv
// tb/tb_coherence_arbiter_n.sv - scoreboard bench for coherence_arbiter_n with cache and RAM models
module tb_coherence_arbiter_n;
    import cpu_types_pkg::*;

    localparam int CPUS  = 4;
    localparam int WORDS = 2;
    localparam int M_NONE = 0, M_RD = 1, M_WBRD = 2, M_INV = 3;
    localparam int K_RD = 0, K_FWD = 1, K_WB = 2, K_INV = 3, K_IF = 4;

    typedef struct {
        int          kind;
        logic [1:0]  cpu;
        logic [1:0]  own;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    logic [CPUS-1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
    logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]       iwait, dwait, ccwait, ccinv;
    logic [CPUS-1:0][31:0] iload, dload, ccsnoopaddr;
    word_t                 ramload, ramaddr, ramstore;
    ramstate_t             ramstate;
    logic                  ramREN, ramWEN;

    int          mode  [CPUS];
    logic [31:0] base  [CPUS];
    logic [0:0]  beat  [CPUS];
    logic [31:0] dat   [CPUS][WORDS];
    logic        owner [CPUS];
    logic        ireq  [CPUS];
    logic [31:0] ibase [CPUS];
    logic [31:0] mem   [256];
    int          lat_cnt, ram_lat;
    logic        ram_err;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 CLK = ~CLK;

    coherence_arbiter_n #(.CPUS(CPUS), .WORDS(WORDS)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iREN        (iREN),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .iaddr       (iaddr),
        .daddr       (daddr),
        .dstore      (dstore),
        .iwait       (iwait),
        .dwait       (dwait),
        .iload       (iload),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .ramload     (ramload),
        .ramstate    (ramstate),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN)
    );

    for (genvar g = 0; g < CPUS; g++) begin : g_cache
        assign dREN[g]    = (mode[g] == M_RD) || (mode[g] == M_WBRD);
        assign dWEN[g]    = (mode[g] == M_WBRD);
        assign cctrans[g] = (mode[g] == M_RD) || (mode[g] == M_INV);
        assign ccwrite[g] = owner[g];
        assign daddr[g]   = base[g] + {29'd0, beat[g], 2'b00};
        assign dstore[g]  = dat[g][beat[g]];
        assign iREN[g]    = ireq[g];
        assign iaddr[g]   = ibase[g];
    end

    assign ramload  = mem[ramaddr[9:2]];
    assign ramstate = !(ramREN || ramWEN) ? FREE :
                      (lat_cnt >= ram_lat) ? ACCESS : (ram_err ? ERROR : BUSY);

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [CPUS-1:0] others(input logic [1:0] c);
        logic [CPUS-1:0] m;
        m    = '1;
        m[c] = 1'b0;
        return m;
    endfunction

    function automatic bit idle_all();
        for (int k = 0; k < CPUS; k++)
            if (mode[k] != M_NONE || ireq[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input int kind, input int cpu, input int own, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.cpu = 2'(cpu); e.own = 2'(own); e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        if (!(((ramREN || ramWEN) && ramstate == ACCESS) || (|ccinv))) return;
        if (q.size() == 0) begin
            chk("spurious_beat", {29'd0, ramREN, ramWEN, |ccinv}, 32'd0);
            return;
        end
        e = q.pop_front();
        case (e.kind)
            K_RD: begin
                chk("rd_ren",    32'(ramREN), 32'd1);
                chk("rd_addr",   ramaddr, e.addr);
                chk("rd_load",   dload[e.cpu], e.data);
                chk("rd_dwait",  32'(dwait[e.cpu]), 32'd0);
                chk("rd_ccwait", 32'(ccwait), 32'(others(e.cpu)));
            end
            K_FWD: begin
                chk("fwd_wen",       32'(ramWEN), 32'd1);
                chk("fwd_addr",      ramaddr, e.addr);
                chk("fwd_store",     ramstore, e.data);
                chk("fwd_load",      dload[e.cpu], e.data);
                chk("fwd_dwait_req", 32'(dwait[e.cpu]), 32'd0);
                chk("fwd_dwait_own", 32'(dwait[e.own]), 32'd0);
                chk("fwd_ccwait",    32'(ccwait), 32'(others(e.cpu)));
            end
            K_WB: begin
                chk("wb_wen",   32'(ramWEN), 32'd1);
                chk("wb_addr",  ramaddr, e.addr);
                chk("wb_store", ramstore, e.data);
                chk("wb_dwait", 32'(dwait[e.cpu]), 32'd0);
            end
            K_INV: begin
                chk("inv_ccinv",   32'(ccinv), 32'(others(e.cpu)));
                chk("inv_ccwait",  32'(ccwait), 32'(others(e.cpu)));
                chk("inv_snoop0",  ccsnoopaddr[0], e.addr);
                chk("inv_snoopN",  ccsnoopaddr[CPUS-1], e.addr);
                chk("inv_dwait",   32'(dwait[e.cpu]), 32'd0);
                chk("inv_ram",     {30'd0, ramREN, ramWEN}, 32'd0);
            end
            default: begin
                chk("if_ren",   32'(ramREN), 32'd1);
                chk("if_addr",  ramaddr, e.addr);
                chk("if_load",  iload[e.cpu], e.data);
                chk("if_iwait", 32'(iwait[e.cpu]), 32'd0);
            end
        endcase
    endtask

    task automatic cycle();
        logic [CPUS-1:0] dadv, iadv;
        logic            busy, acc, wr;
        logic [31:0]     wa, wd;
        @(negedge CLK);
        monitor();
        dadv = ~dwait;
        iadv = ~iwait;
        busy = ramREN || ramWEN;
        acc  = busy && (ramstate == ACCESS);
        wr   = ramWEN && acc;
        wa   = ramaddr;
        wd   = ramstore;
        @(posedge CLK);
        #1;
        if (!busy || acc) lat_cnt = 0;
        else lat_cnt = lat_cnt + 1;
        if (wr) mem[wa[9:2]] = wd;
        for (int k = 0; k < CPUS; k++) begin
            if (iadv[k]) ireq[k] = 1'b0;
            if (dadv[k]) begin
                if (mode[k] == M_INV) begin
                    mode[k] = M_NONE;
                end else if (beat[k] == 1'(WORDS - 1)) begin
                    beat[k] = '0;
                    mode[k] = (mode[k] == M_WBRD) ? M_RD : M_NONE;
                end else begin
                    beat[k] = beat[k] + 1'b1;
                end
            end
        end
    endtask

    task automatic run(input string tag, input int budget, input int exp_cycles);
        int n;
        n = 0;
        while (n < budget && !(idle_all() && q.size() == 0)) begin
            cycle();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_cycles));
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic chk_defaults(input string tag);
        chk({tag, "_dwait"},  32'(dwait), 32'hF);
        chk({tag, "_iwait"},  32'(iwait), 32'hF);
        chk({tag, "_ccwait"}, 32'(ccwait), 32'd0);
        chk({tag, "_ccinv"},  32'(ccinv), 32'd0);
        chk({tag, "_ram"},    {30'd0, ramREN, ramWEN}, 32'd0);
        chk({tag, "_raddr"},  ramaddr, 32'd0);
        chk({tag, "_rstore"}, ramstore, 32'd0);
        chk({tag, "_dload"},  dload[0], 32'd0);
        chk({tag, "_iload"},  iload[0], 32'd0);
        chk({tag, "_snoop"},  ccsnoopaddr[0], 32'd0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < CPUS; k++) begin
            mode[k]  = M_NONE;
            base[k]  = '0;
            beat[k]  = '0;
            owner[k] = 1'b0;
            ireq[k]  = 1'b0;
            ibase[k] = '0;
            for (int w = 0; w < WORDS; w++) dat[k][w] = '0;
        end
        lat_cnt = 0;
    endtask

    task automatic reset_pulse(input string tag);
        nRST = 1'b0;
        #1;
        chk_defaults(tag);
        q.delete();
        clear_model();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic rd(input int k, input logic [31:0] a);
        base[k] = a;
        beat[k] = '0;
        mode[k] = M_RD;
    endtask

    initial begin
        int n;
        nRST    = 1'b1;
        ram_lat = 1;
        ram_err = 1'b0;
        clear_model();
        for (int i = 0; i < 256; i++) mem[i] = init_val(32'(i * 4));
        mem[8'h40] = 32'hA;
        mem[8'h41] = 32'hB;
        #2;
        nRST = 1'b0;

        // clean miss for cache0, request already present while in reset
        rd(0, 32'h100);
        repeat (2) @(posedge CLK);
        #1;
        chk_defaults("reset");
        push(K_RD, 0, 0, 32'h100, 32'hA);
        push(K_RD, 0, 0, 32'h104, 32'hB);
        nRST = 1'b1;
        run("t1_clean_miss_cycles", 50, 6);

        // dirty snoop hit in cache3 forwarded to cache2
        ram_lat   = 0;
        owner[3]  = 1'b1;
        dat[3][0] = 32'h55;
        dat[3][1] = 32'h66;
        rd(2, 32'h200);
        push(K_FWD, 2, 3, 32'h200, 32'h55);
        push(K_FWD, 2, 3, 32'h204, 32'h66);
        run("t2_forward_cycles", 50, 4);
        owner[3] = 1'b0;
        chk("t2_ram_word0", mem[8'h80], 32'h55);
        chk("t2_ram_word1", mem[8'h81], 32'h66);

        // write hit on a shared line: invalidate only
        base[1] = 32'h40;
        mode[1] = M_INV;
        push(K_INV, 1, 0, 32'h40, 32'h0);
        run("t3_inv_cycles", 20, 2);

        // reset in the middle of a block, then the block restarts from word 0
        ram_lat = 2;
        rd(0, 32'h100);
        push(K_RD, 0, 0, 32'h100, 32'hA);
        push(K_RD, 0, 0, 32'h104, 32'hB);
        n = 0;
        while (n < 40 && q.size() > 1) begin
            cycle();
            n++;
        end
        chk("t4_first_word_done", 32'(q.size()), 32'd1);
        reset_pulse("t4_midreset");
        ram_lat = 1;
        rd(0, 32'h100);
        push(K_RD, 0, 0, 32'h100, 32'hA);
        push(K_RD, 0, 0, 32'h104, 32'hB);
        run("t4_restart_cycles", 50, 6);

        // two caches competing from drr=0: grants alternate 0,1,0,1
        reset_pulse("t5_reset");
        ram_lat = 0;
        for (int r = 0; r < 2; r++) begin
            rd(0, 32'h140 + 32'(r * 16));
            rd(1, 32'h1C0 + 32'(r * 16));
            for (int k = 0; k < 2; k++)
                for (int w = 0; w < WORDS; w++)
                    push(K_RD, k, 0, base[k] + 32'(w * 4), init_val(base[k] + 32'(w * 4)));
            run($sformatf("t5_round%0d_cycles", r), 60, 8);
        end

        // victim writeback, then the fill, then the waiting ifetch; RAM stalls via ERROR
        ram_lat   = 2;
        ram_err   = 1'b1;
        dat[0][0] = 32'h1111_0080;
        dat[0][1] = 32'h2222_0084;
        base[0]   = 32'h80;
        beat[0]   = '0;
        mode[0]   = M_WBRD;
        ibase[1]  = 32'h300;
        ireq[1]   = 1'b1;
        push(K_WB, 0, 0, 32'h80, 32'h1111_0080);
        push(K_WB, 0, 0, 32'h84, 32'h2222_0084);
        push(K_RD, 0, 0, 32'h80, 32'h1111_0080);
        push(K_RD, 0, 0, 32'h84, 32'h2222_0084);
        push(K_IF, 1, 0, 32'h300, init_val(32'h300));
        run("t6_wb_fill_ifetch_cycles", 100, 19);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coherence_arbiter_n.md
# coherence_arbiter_n

N-cache snooping coherence controller and RAM arbiter between the private L1 caches and the single-ported RAM. It round-robin arbitrates data and instruction requests from `CPUS` caches and broadcasts snoops and invalidates to every non-requesting cache. Dirty snoop hits are forwarded cache-to-cache while the same words are written through to RAM in the same beat. It generalises the two-cache controller to any cache count and any block length, and adds fair arbitration and instruction-fetch service.

## Interface
- `CPUS`, default 2, number of caches (≥2).
- `WORDS`, default 2, words per cache block (power of two, ≥1).
- `CLK`  in  1  clock; all state updates on rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`, `dREN`, `dWEN`, `cctrans`, `ccwrite`  in  [CPUS]  per-cache request and coherence flags.
- `iaddr`, `daddr`, `dstore`  in  [CPUS] x 32  per-cache addresses and store data; the cache presents the address of the current word.
- `iwait`, `dwait`  out  [CPUS]  per-cache stall; 0 means the beat completed.
- `iload`, `dload`  out  [CPUS] x 32  fill data.
- `ccwait`, `ccinv`  out  [CPUS]  snoop-hold and invalidate strobes.
- `ccsnoopaddr`  out  [CPUS] x 32  snoop address, driven identically to every cache.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  `ramstate_t`  FREE/BUSY/ACCESS/ERROR.
- `ramaddr`, `ramstore`  out  32  RAM address and write data.
- `ramREN`, `ramWEN`  out  1  RAM strobes; mutually exclusive.

## Operation
- States: IDLE, SNOOP, DATA, WB, INV, IFETCH. Registers: `state`, `req` and `own` (index, log2 CPUS bits), `hit`, `wcnt` (log2 WORDS bits), `drr`, `irr` (round-robin pointers).
- IDLE: the data arbiter scans caches starting at `drr`. Cache k qualifies when `dWEN[k]`, or `dREN[k]&cctrans[k]`, or `cctrans[k]` alone. First qualifier wins and becomes `req`.
  - `dWEN[k]` → WB. This also applies when `dREN[k]` is set: the victim writeback precedes the fill.
  - `dREN[k]&cctrans[k]` → SNOOP.
  - `cctrans[k]` only (write hit on a shared line) → INV.
  - With no data qualifier and any `iREN`, the instruction arbiter picks from `irr` → IFETCH.
- SNOOP (1 cycle): `ccwait[j]=1` for all j≠req. `ccsnoopaddr=daddr[req]`. Latch `hit=|ccwrite[j≠req]` and `own` = lowest such j. → DATA.
- DATA, per word:
  - `hit=1`: `ramWEN=1`, `ramaddr=daddr[req]`, `ramstore=dload[req]=dstore[own]`. `dwait[req]=dwait[own]=~(ramstate==ACCESS)`.
  - `hit=0`: `ramREN=1`, `ramaddr=daddr[req]`, `dload[req]=ramload`, `dwait[req]=~ACCESS`.
  - `ccwait[j≠req]` is held for the whole state.
  - On ACCESS, `wcnt` increments. On the beat with `wcnt==WORDS-1`: `wcnt←0`, `drr←req+1` (mod CPUS), → IDLE.
- WB, per word: `ramWEN=1`, `ramaddr=daddr[req]`, `ramstore=dstore[req]`, `dwait[req]=~ACCESS`. Same counter and exit rule as DATA.
- INV (1 cycle): `ccinv[j]=ccwait[j]=1` for j≠req. `ccsnoopaddr=daddr[req]`. `dwait[req]=0`. `drr←req+1`, → IDLE.
- IFETCH: `ramREN=1`, `ramaddr=iaddr[irr-winner]`, `iload=ramload`, `iwait=~ACCESS`. On ACCESS: `irr←winner+1`, → IDLE. Single word.
- Defaults, any state (including during reset): all `dwait`/`iwait`=1. `ccwait`/`ccinv`/`ramREN`/`ramWEN`=0. `ramaddr`/`ramstore`/`dload`/`iload`/`ccsnoopaddr`=0.
- Boundary rules:
  - `ramstate` ERROR or BUSY is a stall; the state is held.
  - Data requests beat instruction requests in the same cycle.
  - Requests deasserted mid-transaction are ignored until the block completes.
  - `nRST` low: state→IDLE; `wcnt`, `drr`, `irr`, `req`, `own`, `hit`→0.

## Timing
- Grant decision in IDLE; the transaction starts the next cycle.
- Clean miss: 1 (IDLE) + 1 (SNOOP) + WORDS×(RAM latency) cycles.
- Forwarded miss costs the same; RAM is updated in the same beats, so the owner may downgrade to S.
- INV: 2 cycles total. IFETCH: 1 + RAM latency.
- All outputs are combinational from registered state and inputs. There are no combinational paths from `ccwrite` to outputs except in DATA via the registered `hit`.

## Structure
- `cpu_types_pkg` gains `cc_state_t` (the six states). `word_t` and `ramstate_t` are reused from it.
- Sub-module `rr_arbiter #(N)`: request vector plus pointer in, one-hot grant plus index out, purely combinational. It is instantiated twice, once for data and once for instructions.

## Test plan
- Reset, then cache0 `dREN`+`cctrans` at 0x100, no snoop hit, RAM returns 0xA, 0xB → `dload[0]` 0xA then 0xB, `dwait[0]` low on each ACCESS, `ccwait[1]` high throughout.
- CPUS=4: cache2 reads 0x200 while cache3 asserts `ccwrite` with `dstore` 0x55, 0x66 → `dload[2]` and `ramstore` both 0x55, 0x66; `ramWEN`=1; `dwait[3]` low on the same beats.
- Caches 0 and 1 request simultaneously and repeatedly, `drr`=0 → grants alternate 0,1,0,1; neither waits more than one transaction.
- Cache1 `cctrans` only, daddr 0x40 → one cycle with `ccinv[0]`=1, `ccsnoopaddr`=0x40, `dwait[1]`=0; back in IDLE next cycle.
- Cache0 `dWEN`+`dREN` at 0x80 while cache1 `iREN` → WB of 2 words, then snoop and fill for cache0, then IFETCH for cache1.
- `nRST` pulsed mid-DATA after word 0 → all outputs at defaults immediately; the next request restarts at `wcnt`=0.
